// File: rtl/trainled_pkg.sv
// Shared constants and FSM encoding for the TrainLED frame scheduler.
package trainled_pkg;

    localparam int BIT_CLKS      = 12;
    localparam int PH_HIGH_LAST  = 3;
    localparam int PH_DATA_LAST  = 7;
    localparam int RX_RESET_CLKS = 96;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SEND = 2'd2
    } state_t;

endpackage

// File: rtl/trainled_bit_tx.sv
// Purpose: 12-phase single-bit serializer (4 high, 4 data, 4 low) for the TrainLED line.
// Latency: o_dout is a flop; phase 0 (high) appears the cycle after a bit is accepted.
// Backpressure: o_bit_ready only when idle or in the last phase, so bits chain gap-free.
module trainled_bit_tx
    import trainled_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_bit_valid,
    input  logic i_bit_data,
    output logic o_bit_ready,
    output logic o_dout
);

    logic       r_active;
    logic [3:0] r_phase;
    logic       r_data;
    logic       r_dout;

    logic       w_accept;
    logic       w_last_ph;
    logic       w_active_nxt;
    logic [3:0] w_phase_nxt;
    logic       w_data_nxt;
    logic       w_dout_nxt;

    assign w_last_ph   = (r_phase == 4'(BIT_CLKS - 1));
    assign o_bit_ready = !r_active || w_last_ph;
    assign w_accept    = i_bit_valid && o_bit_ready;
    assign o_dout      = r_dout;

    // Line level is derived from the next phase so it lands in the same flop stage as the phase.
    always_comb begin
        w_active_nxt = r_active;
        w_phase_nxt  = r_phase;
        w_data_nxt   = r_data;
        if (w_accept) begin
            w_active_nxt = 1'b1;
            w_phase_nxt  = '0;
            w_data_nxt   = i_bit_data;
        end else if (r_active) begin
            if (w_last_ph) begin
                w_active_nxt = 1'b0;
                w_phase_nxt  = '0;
            end else begin
                w_phase_nxt  = r_phase + 4'd1;
            end
        end
        w_dout_nxt = 1'b0;
        if (w_active_nxt) begin
            if (w_phase_nxt <= 4'(PH_HIGH_LAST)) begin
                w_dout_nxt = 1'b1;
            end else if (w_phase_nxt <= 4'(PH_DATA_LAST)) begin
                w_dout_nxt = w_data_nxt;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active <= 1'b0;
            r_phase  <= '0;
            r_data   <= 1'b0;
            r_dout   <= 1'b0;
        end else begin
            r_active <= w_active_nxt;
            r_phase  <= w_phase_nxt;
            r_data   <= w_data_nxt;
            r_dout   <= w_dout_nxt;
        end
    end

endmodule

// File: rtl/trainled_frame_ctrl.sv
// Purpose: per-LED PWM register file plus frame scheduler (reset gap, then serialized values).
// Latency: 1 + GAP_CLKS + 48*NUM_LEDS cycles from start to the done pulse; dout is a flop.
// Backpressure: start is ignored while busy; writes are always accepted and hit the next frame.
module trainled_frame_ctrl
    import trainled_pkg::*;
#(
    parameter  int NUM_LEDS = 4,
    parameter  int GAP_CLKS = 128,
    localparam int AW       = $clog2((NUM_LEDS > 1) ? NUM_LEDS : 2)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [3:0]    i_wr_data,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_dout
);

    localparam int FB = 4 * NUM_LEDS;
    localparam int BW = $clog2(FB) + 1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_gap;
    logic [BW-1:0] r_bit;
    logic [FB-1:0] r_shift;
    logic [FB-1:0] w_snap;
    logic [3:0]    r_val     [NUM_LEDS];
    logic [3:0]    w_val_nxt [NUM_LEDS];
    logic          r_done;

    logic          w_gap_last;
    logic          w_bit_last;
    logic          w_load;
    logic          w_bit_valid;
    logic          w_bit_ready;
    logic          w_done_nxt;

    assign w_gap_last = (r_gap == 8'(GAP_CLKS - 1));
    assign w_bit_last = (r_bit == BW'(FB - 1));
    assign o_done     = r_done;

    // Write-first view of the register file; the snapshot is taken from it.
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            w_val_nxt[i] = r_val[i];
        end
        if (i_wr_en && ({1'b0, i_wr_addr} < (AW + 1)'(NUM_LEDS))) begin
            w_val_nxt[i_wr_addr] = i_wr_data;
        end
    end

    // Pixel 0 lands in the MSBs so the frame shifts out left, MSB first per value.
    always_comb begin
        w_snap = '0;
        for (int k = 0; k < NUM_LEDS; k++) begin
            w_snap[FB - 1 - 4 * k -: 4] = w_val_nxt[k];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_val[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_val[i] <= w_val_nxt[i];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start)                   w_state_nxt = GAP;
            GAP:     if (w_gap_last)                w_state_nxt = SEND;
            SEND:    if (w_bit_ready && w_bit_last) w_state_nxt = IDLE;
            default:                                w_state_nxt = IDLE;
        endcase
    end

    // The first bit is handed over in the last gap cycle so its high phase starts right after.
    always_comb begin
        o_busy      = (r_state != IDLE);
        w_load      = (r_state == IDLE) && i_start;
        w_bit_valid = ((r_state == GAP) && w_gap_last) ||
                      ((r_state == SEND) && w_bit_ready && !w_bit_last);
        w_done_nxt  = (r_state == SEND) && w_bit_ready && w_bit_last;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gap   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (w_load) begin
                r_shift <= w_snap;
                r_gap   <= '0;
                r_bit   <= '0;
            end else begin
                if (r_state == GAP) begin
                    r_gap <= r_gap + 8'd1;
                end
                if (w_bit_valid) begin
                    r_shift <= {r_shift[FB-2:0], 1'b0};
                    if (r_state == SEND) begin
                        r_bit <= r_bit + BW'(1);
                    end
                end
            end
        end
    end

    trainled_bit_tx u_bit_tx (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_bit_valid (w_bit_valid),
        .i_bit_data  (r_shift[FB-1]),
        .o_bit_ready (w_bit_ready),
        .o_dout      (o_dout)
    );

endmodule

// File: doc/trainled_frame_ctrl.md
# trainled_frame_ctrl

Frame scheduler that drives the `din` input of a daisy chain of TrainLED pixels. A host writes 4-bit PWM values into a per-LED register file, then issues `start`. The block emits an idle-low gap long enough to reset every receiver in the chain, then serializes all values in the chain's 12-clock bit encoding. It sits between host/config logic and the chain's first pixel.

## Interface
- `NUM_LEDS`, default 4: pixels in the chain; 1..16.
- `GAP_CLKS`, default 128: idle-low clocks before a frame; 104..255 (must exceed the 96-clock receiver reset time plus margin).
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: write strobe into the value register file.
- `wr_addr` in `$clog2(NUM_LEDS)` (min 1): pixel index; 0 is the pixel nearest the block.
- `wr_data` in 4: PWM value.
- `start` in 1: single-cycle frame request.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse when a frame completes.
- `dout` out 1: registered serial line to the chain.

## Operation
- Register file `val[NUM_LEDS]` x 4 bits, reset to 0.
  - Written whenever `wr_en=1`, including while busy.
  - A write with `wr_addr >= NUM_LEDS` is ignored.
- Snapshot: on an accepted `start`, copy all values into a frame shift buffer of `4*NUM_LEDS` bits.
  - If a write occurs in the same cycle as `start`, the new value is included (write-first).
  - Writes made during a frame affect only the next frame.
- FSM states are IDLE, GAP, SEND.
  - IDLE: `dout=0`, `busy=0`. `start=1` leads to GAP; load the snapshot and clear the counter.
  - GAP: `dout=0` for exactly `GAP_CLKS` cycles, then go to SEND with phase 0 and bit 0.
  - SEND: phase counter runs 0..11 for each bit.
    - Phases 0-3: `dout=1`.
    - Phases 4-7: `dout` = current data bit.
    - Phases 8-11: `dout=0`.
  - Bit order: pixel 0 first, MSB first within each value. Pixel k's bits are frame bits 4k..4k+3.
  - After phase 11 of bit `4*NUM_LEDS-1`, go to IDLE and pulse `done`.
- `start` while `busy=1` is ignored; it is neither queued nor an error.
- Counters:
  - Phase counter is 4 bits and wraps 11 to 0.
  - Bit index is `$clog2(4*NUM_LEDS)+1` bits.
  - Gap counter is 8 bits.
  - No arithmetic may overflow within the legal parameter ranges.
- Reset mid-frame: all state clears immediately (async). `dout=0`, `busy=0`, `done=0`, state IDLE, register file cleared. The chain self-resets via the low line.

## Timing
- Reset values: `dout=0`, `busy=0`, `done=0`.
- Start sampled at cycle T:
  - `busy=1` from T+1.
  - `dout` is low for cycles T+1..T+GAP_CLKS.
  - The first rising edge of `dout` appears at T+GAP_CLKS+1.
- Each bit takes 12 cycles, so SEND lasts `48*NUM_LEDS` cycles.
- At T+1+GAP_CLKS+48*NUM_LEDS: `done=1` for one cycle, `busy=0`, `dout=0`.
- A new `start` in that same cycle is accepted: back-to-back frames are allowed.
- Total frame latency is `1+GAP_CLKS+48*NUM_LEDS` cycles.
- `dout` is driven straight from a flop, with no combinational path from inputs.

## Structure
- Package `trainled_pkg` holds:
  - constants `BIT_CLKS=12`, `PH_HIGH_LAST=3`, `PH_DATA_LAST=7`, `RX_RESET_CLKS=96`;
  - the state enum `{IDLE, GAP, SEND}`.
- Sub-module `trainled_bit_tx`: a 12-phase single-bit serializer.
  - Inputs: `bit_valid`, `bit_data`.
  - Outputs: `bit_ready`, registered `dout`.
  - The top FSM feeds it from the frame shift buffer.

## Test plan
- Reset: hold `rst_n=0` during activity, then release. Required: `dout=busy=done=0`, and a subsequent all-zero frame sends 16 bits that are all 0 (high 4, low 8).
- Basic frame (NUM_LEDS=4, GAP_CLKS=128): write 0x9,0x3,0xF,0x0, start at T. Required:
  - `dout` low T+1..T+128;
  - data-phase bits `1001 0011 1111 0000`;
  - `done` at T+321.
- Chain check: drive 4 TrainLED models from `dout`. Required: each pixel's latched PWM equals its written value; pixel 0 forwards the 12 later bits.
- Write during busy: mid-SEND, write pixel 2 = 0x5. Required: the current frame still sends 0xF; the next frame sends 0x5.
- Ignored requests:
  - `start` pulsed while busy changes nothing;
  - a write to `wr_addr=5` (NUM_LEDS=4) leaves all values unchanged;
  - start in the `done` cycle begins a new frame at once.
- Async reset mid-SEND, asserted for 1 cycle at a phase-5 data bit. Required: `dout` falls without waiting for a clock edge; `busy` clears; a later start sends a full gap and a frame of zeros.
